// File: rtl/mmss_pkg.sv
// Shared types and helpers for the multi-master/single-slave arbiter.
// Round-robin arbitration is enabled by defining MMSS_ROUND_ROBIN_EN.
package mmss_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } mmss_state_e;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/slv_interface.sv
// Request/response handshake: address/write channel plus read-response channel.
interface slv_interface #(
  parameter int WIDTH   = 32,
  parameter int ARWIDTH = 16
);

  logic                 avalid;
  logic                 aready;
  logic [ARWIDTH-1:0]   addr;
  logic                 awren;
  logic [WIDTH/8-1:0]   awstrb;
  logic [WIDTH-1:0]     awdata;
  logic                 rvalid;
  logic                 rready;
  logic [WIDTH-1:0]     rdata;

  modport master (
    output avalid, addr, awren, awstrb, awdata, rready,
    input  aready, rvalid, rdata
  );

  modport slv (
    input  avalid, addr, awren, awstrb, awdata, rready,
    output aready, rvalid, rdata
  );

endinterface

// File: rtl/mmss_owner_fifo.sv
// In-order owner FIFO: records which master issued each accepted request so
// responses can be routed back. Push while full is legal only together with pop.
module mmss_owner_fifo
  import mmss_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int IDX_W = 1,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  input  logic             pop,
  output logic [IDX_W-1:0] head_idx,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [IDX_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state updates use <= so all registers sample the pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only read after it has been written, so the count alone defines validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_idx;
  end

  assign head_idx = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);

endmodule

// File: rtl/multi_master_single_slave.sv
// Arbitrates N_MASTERS upstream ports onto one downstream slave with in-order response
// routing. Define MMSS_ROUND_ROBIN_EN for round-robin grants; otherwise lowest index wins.
module multi_master_single_slave
  import mmss_pkg::*;
#(
  parameter int N_MASTERS       = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter int WIDTH           = 32,
  parameter int ARWIDTH         = 16
) (
  input logic           clk,
  input logic           rst,
  slv_interface.slv     master [N_MASTERS],
  slv_interface.master  slv
);

  localparam int IDX_W = idx_w(N_MASTERS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  if (N_MASTERS < 2) begin : g_bad_n
    $error("multi_master_single_slave: N_MASTERS must be >= 2");
  end
  if ((MAX_OUTSTANDING < 1) || ((MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0)) begin : g_bad_max
    $error("multi_master_single_slave: MAX_OUTSTANDING must be a power of two >= 1");
  end
  if (($bits(slv.rdata) != WIDTH) || ($bits(slv.addr) != ARWIDTH)) begin : g_bad_slv_w
    $error("multi_master_single_slave: downstream port WIDTH/ARWIDTH mismatch");
  end

  // Flattened view of the upstream ports so they can be indexed by the grant.
  logic [N_MASTERS-1:0] m_avalid, m_awren, m_rready, m_aready, m_rvalid;
  logic [ARWIDTH-1:0]   m_addr   [N_MASTERS];
  logic [WIDTH/8-1:0]   m_awstrb [N_MASTERS];
  logic [WIDTH-1:0]     m_awdata [N_MASTERS];

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_port
    if (($bits(master[i].rdata) != WIDTH) || ($bits(master[i].addr) != ARWIDTH)) begin : g_bad_w
      $error("multi_master_single_slave: upstream port WIDTH/ARWIDTH mismatch");
    end
    assign m_avalid[i]      = master[i].avalid;
    assign m_awren[i]       = master[i].awren;
    assign m_rready[i]      = master[i].rready;
    assign m_addr[i]        = master[i].addr;
    assign m_awstrb[i]      = master[i].awstrb;
    assign m_awdata[i]      = master[i].awdata;
    assign master[i].aready = m_aready[i];
    assign master[i].rvalid = m_rvalid[i];
    assign master[i].rdata  = slv.rdata;
  end

  mmss_state_e      state_q, state_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0] arb_idx, g;
  logic             issue_ok, push, pop, slv_avalid, slv_rready;
  logic [IDX_W-1:0] head_idx;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;

`ifdef MMSS_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  // First requester at or after rr_ptr, wrapping; rr_ptr itself when idle.
  always_comb begin
    int  j;
    logic found;
    arb_idx = rr_ptr_q;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < N_MASTERS; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= N_MASTERS) j = j - N_MASTERS;
      if (!found && m_avalid[IDX_W'(j)]) begin
        arb_idx = IDX_W'(j);
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (push) rr_ptr_d = (g == IDX_W'(N_MASTERS - 1)) ? '0 : g + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    arb_idx = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      if (m_avalid[IDX_W'(k)]) arb_idx = IDX_W'(k);
    end
  end
`endif

  // A stalled request keeps its grant so the downstream address stays stable.
  assign g = (state_q == LOCKED) ? lock_idx_q : arb_idx;

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    case (state_q)
      IDLE: begin
        if (slv_avalid && !slv.aready) begin
          state_d    = LOCKED;
          lock_idx_d = g;
        end
      end
      LOCKED:  if (push) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // A pop in the same cycle frees a slot, so a full tracker can still issue.
  assign slv_rready = ~fifo_empty & m_rready[head_idx];
  assign pop        = slv.rvalid & slv_rready;
  assign issue_ok   = (fifo_count < CNT_W'(MAX_OUTSTANDING)) | pop;
  assign slv_avalid = m_avalid[g] & issue_ok;
  assign push       = slv_avalid & slv.aready;

  assign slv.avalid = slv_avalid;
  assign slv.addr   = m_addr[g];
  assign slv.awren  = m_awren[g];
  assign slv.awstrb = m_awstrb[g];
  assign slv.awdata = m_awdata[g];
  assign slv.rready = slv_rready;

  always_comb begin
    m_aready    = '0;
    m_aready[g] = slv.aready & issue_ok;
  end

  always_comb begin
    m_rvalid           = '0;
    m_rvalid[head_idx] = slv.rvalid & ~fifo_empty;
  end

  mmss_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .IDX_W (IDX_W)
  ) u_owner_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_idx (g),
    .pop      (pop),
    .head_idx (head_idx),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // A response with nothing outstanding has no owner; it is dropped and flagged.
  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
    !(slv.rvalid && fifo_empty));

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_multi_master_single_slave.sv
// Directed bench for multi_master_single_slave with three masters and two outstanding slots.
module tb_multi_master_single_slave;

  localparam int N    = 3;
  localparam int MAXO = 2;
  localparam int W    = 32;
  localparam int AW   = 16;
`ifdef MMSS_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  slv_interface #(.WIDTH(W), .ARWIDTH(AW)) m_if [N] ();
  slv_interface #(.WIDTH(W), .ARWIDTH(AW)) s_if ();

  logic [N-1:0]   m_avalid, m_awren, m_rready, m_aready, m_rvalid;
  logic [AW-1:0]  m_addr   [N];
  logic [W/8-1:0] m_awstrb [N];
  logic [W-1:0]   m_awdata [N];
  logic [W-1:0]   m_rdata  [N];

  for (genvar i = 0; i < N; i++) begin : g_m
    assign m_if[i].avalid = m_avalid[i];
    assign m_if[i].addr   = m_addr[i];
    assign m_if[i].awren  = m_awren[i];
    assign m_if[i].awstrb = m_awstrb[i];
    assign m_if[i].awdata = m_awdata[i];
    assign m_if[i].rready = m_rready[i];
    assign m_aready[i]    = m_if[i].aready;
    assign m_rvalid[i]    = m_if[i].rvalid;
    assign m_rdata[i]     = m_if[i].rdata;
  end

  logic         s_aready, s_rvalid;
  logic [W-1:0] s_rdata;
  assign s_if.aready = s_aready;
  assign s_if.rvalid = s_rvalid;
  assign s_if.rdata  = s_rdata;

  multi_master_single_slave #(
    .N_MASTERS       (N),
    .MAX_OUTSTANDING (MAXO),
    .WIDTH           (W),
    .ARWIDTH         (AW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .master (m_if),
    .slv    (s_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    m_avalid = '0;
    m_awren  = '0;
    m_rready = '1;
    for (int i = 0; i < N; i++) begin
      m_addr[i]   = '0;
      m_awstrb[i] = '0;
      m_awdata[i] = '0;
    end
    s_aready = 1'b0;
    s_rvalid = 1'b0;
    s_rdata  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [63:0] oh(input int idx);
    return 64'(1) << idx;
  endfunction

  int gb, gd;
  int g6 [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset then idle: everything quiet.
    do_reset();
    #1;
    check("rst_avalid", 64'(s_if.avalid), 64'(0));
    check("rst_addr",   64'(s_if.addr),   64'(0));
    check("rst_awren",  64'(s_if.awren),  64'(0));
    check("rst_awstrb", 64'(s_if.awstrb), 64'(0));
    check("rst_awdata", 64'(s_if.awdata), 64'(0));
    check("rst_rready", 64'(s_if.rready), 64'(0));
    check("rst_aready", 64'(m_aready),    64'(0));
    check("rst_rvalid", 64'(m_rvalid),    64'(0));

    // Master0 reads 0x100, slave answers one cycle later.
    m_avalid = 3'b001;
    m_addr[0] = 16'h0100;
    s_aready = 1'b1;
    #1;
    check("rd_avalid", 64'(s_if.avalid), 64'(1));
    check("rd_addr",   64'(s_if.addr),   64'h100);
    check("rd_aready", 64'(m_aready),    64'b001);
    tick();
    m_avalid = '0;
    s_rvalid = 1'b1;
    s_rdata  = 32'h1234_5678;
    #1;
    check("rd_rvalid", 64'(m_rvalid),    64'b001);
    check("rd_rdata",  64'(m_rdata[0]),  64'h1234_5678);
    check("rd_rready", 64'(s_if.rready), 64'(1));
    tick();
    s_rvalid = 1'b0;
    #1;
    check("rd_empty_rready", 64'(s_if.rready), 64'(0));

    // Masters 0 and 1 request continuously; pops begin once two are outstanding.
    do_reset();
    gb = RR ? 1 : 0;
    gd = RR ? 1 : 0;
    m_avalid  = 3'b011;
    m_addr[0] = 16'h0010;
    m_addr[1] = 16'h0020;
    s_aready  = 1'b1;
    #1;
    check("cont_a_aready", 64'(m_aready), oh(0));
    check("cont_a_addr",   64'(s_if.addr), 64'h10);
    tick();
    #1;
    check("cont_b_aready", 64'(m_aready), oh(gb));
    check("cont_b_addr",   64'(s_if.addr), (gb == 1) ? 64'h20 : 64'h10);
    tick();
    s_rvalid = 1'b1;
    s_rdata  = 32'h0000_00C0;
    #1;
    check("cont_c_rvalid", 64'(m_rvalid), oh(0));
    check("cont_c_aready", 64'(m_aready), oh(0));
    tick();
    s_rdata = 32'h0000_00D0;
    #1;
    check("cont_d_rvalid", 64'(m_rvalid), oh(gb));
    check("cont_d_aready", 64'(m_aready), oh(gd));
    tick();
    m_avalid = '0;
    #1;
    check("cont_e_rvalid", 64'(m_rvalid),    oh(0));
    check("cont_e_avalid", 64'(s_if.avalid), 64'(0));
    tick();
    #1;
    check("cont_f_rvalid", 64'(m_rvalid), oh(gd));
    tick();
    s_rvalid = 1'b0;

    // Slave stalls master0 for three cycles while master1 joins.
    do_reset();
    m_avalid  = 3'b001;
    m_addr[0] = 16'h0300;
    #1;
    check("stall_avalid", 64'(s_if.avalid), 64'(1));
    check("stall_addr1",  64'(s_if.addr),   64'h300);
    check("stall_aready", 64'(m_aready),    64'(0));
    tick();
    m_avalid  = 3'b011;
    m_addr[1] = 16'h0310;
    #1;
    check("stall_addr2", 64'(s_if.addr), 64'h300);
    tick();
    #1;
    check("stall_addr3", 64'(s_if.addr), 64'h300);
    tick();
    s_aready = 1'b1;
    #1;
    check("stall_accept", 64'(m_aready),  64'b001);
    check("stall_addr4",  64'(s_if.addr), 64'h300);
    tick();
    m_addr[0] = 16'h0304;
    #1;
    check("stall_next_aready", 64'(m_aready),  RR ? 64'b010 : 64'b001);
    check("stall_next_addr",   64'(s_if.addr), RR ? 64'h310 : 64'h304);
    tick();

    // Stalled master2 keeps the grant although master0 would otherwise win.
    do_reset();
    m_avalid  = 3'b100;
    m_addr[2] = 16'h0320;
    #1;
    check("lock_aready0", 64'(m_aready),  64'(0));
    check("lock_addr0",   64'(s_if.addr), 64'h320);
    tick();
    m_avalid  = 3'b101;
    m_addr[0] = 16'h0330;
    #1;
    check("lock_addr1", 64'(s_if.addr), 64'h320);
    tick();
    s_aready = 1'b1;
    #1;
    check("lock_accept", 64'(m_aready), 64'b100);
    tick();
    m_avalid = 3'b001;
    #1;
    check("lock_release_aready", 64'(m_aready),  64'b001);
    check("lock_release_addr",   64'(s_if.addr), 64'h330);
    tick();

    // Outstanding limit: third request waits until a response drains the same cycle.
    do_reset();
    m_avalid  = 3'b001;
    m_addr[0] = 16'h0400;
    s_aready  = 1'b1;
    #1;
    check("max_1", 64'(m_aready), 64'b001);
    tick();
    #1;
    check("max_2", 64'(m_aready), 64'b001);
    tick();
    #1;
    check("max_3_aready", 64'(m_aready),    64'(0));
    check("max_3_avalid", 64'(s_if.avalid), 64'(0));
    tick();
    s_rvalid = 1'b1;
    s_rdata  = 32'h0000_0044;
    #1;
    check("max_pp_rready", 64'(s_if.rready), 64'(1));
    check("max_pp_rvalid", 64'(m_rvalid),    64'b001);
    check("max_pp_aready", 64'(m_aready),    64'b001);
    check("max_pp_avalid", 64'(s_if.avalid), 64'(1));
    tick();
    s_rvalid = 1'b0;
    #1;
    check("max_still_full", 64'(m_aready), 64'(0));
    tick();

    // Master1 write, then backpressure on its response.
    do_reset();
    m_avalid    = 3'b010;
    m_addr[1]   = 16'h0500;
    m_awren     = 3'b010;
    m_awstrb[1] = 4'hF;
    m_awdata[1] = 32'hDEAD_BEEF;
    s_aready    = 1'b1;
    #1;
    check("wr_awren",  64'(s_if.awren),  64'(1));
    check("wr_awstrb", 64'(s_if.awstrb), 64'hF);
    check("wr_awdata", 64'(s_if.awdata), 64'hDEAD_BEEF);
    check("wr_aready", 64'(m_aready),    64'b010);
    tick();
    m_avalid = '0;
    m_awren  = '0;
    m_rready = 3'b101;
    s_rvalid = 1'b1;
    s_rdata  = 32'h0000_0055;
    #1;
    check("bp_rready1", 64'(s_if.rready), 64'(0));
    check("bp_rvalid1", 64'(m_rvalid),    64'b010);
    tick();
    #1;
    check("bp_rready2", 64'(s_if.rready), 64'(0));
    check("bp_rvalid2", 64'(m_rvalid),    64'b010);
    tick();
    m_rready = 3'b111;
    #1;
    check("bp_release", 64'(s_if.rready), 64'(1));
    check("bp_rdata",   64'(m_rdata[1]),  64'h55);
    tick();
    s_rvalid = 1'b0;
    #1;
    check("bp_drained", 64'(s_if.rready), 64'(0));

    // Masters 0 and 2 request continuously with one response per cycle.
    do_reset();
    for (int k = 0; k < 4; k++) g6[k] = (RR && (k % 2 == 1)) ? 2 : 0;
    m_avalid  = 3'b101;
    m_addr[0] = 16'h0600;
    m_addr[2] = 16'h0620;
    s_aready  = 1'b1;
    #1;
    check("pri_aready0", 64'(m_aready), oh(g6[0]));
    tick();
    s_rvalid = 1'b1;
    for (int k = 1; k < 4; k++) begin
      s_rdata = 32'(k);
      #1;
      check($sformatf("pri_aready%0d", k), 64'(m_aready), oh(g6[k]));
      check($sformatf("pri_rvalid%0d", k), 64'(m_rvalid), oh(g6[k-1]));
      tick();
    end
    m_avalid = 3'b100;
    #1;
    check("pri_m2_aready", 64'(m_aready), 64'b100);
    check("pri_m2_rvalid", 64'(m_rvalid), oh(g6[3]));
    tick();
    m_avalid = '0;
    #1;
    check("pri_last_rvalid", 64'(m_rvalid), 64'b100);
    tick();
    s_rvalid = 1'b0;
    #1;
    check("pri_empty", 64'(s_if.rready), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
